// File: rtl/difftest_fpcsr_pkg.sv
// FCSR field layout and the snapshot record shared by the
// fpcsr difftest collector and its queue.
package difftest_fpcsr_pkg;

  localparam int FFLAGS_W = 5;
  localparam int FRM_W    = 3;
  localparam int FRM_LSB  = 5;
  localparam int FCSR_W   = FFLAGS_W + FRM_W;
  localparam int SNAP_FCSR_W = 64;
  localparam int COREID_W = 8;

  typedef struct packed {
    logic [SNAP_FCSR_W-1:0] fcsr;
    logic [COREID_W-1:0]    coreid;
  } snap_t;

  function automatic logic [SNAP_FCSR_W-1:0] fcsr_ext(
    input logic [FCSR_W-1:0] v
  );
    return {{(SNAP_FCSR_W-FCSR_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/difftest_snap_fifo.sv
// Count-based synchronous FIFO; head is read straight from
// storage so a push at edge N is visible in cycle N+1.
module difftest_snap_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts when the head leaves this cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + PW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/difftest_fpcsr_collector.sv
// Shadows fcsr from FP commits and queues snapshots for difftest.
// DIFFTEST_FPCSR_CHANGE_ONLY_EN: enqueue only on a changed value.
module difftest_fpcsr_collector
  import difftest_fpcsr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    io_coreid,
  input  logic          commit_valid,
  input  logic          fflags_valid,
  input  logic [4:0]    fflags,
  input  logic          frm_wen,
  input  logic [2:0]    frm_wdata,
  input  logic          fcsr_wen,
  input  logic [7:0]    fcsr_wdata,
  input  logic          out_ready,
  output logic          out_enable,
  output logic [63:0]   out_fcsr,
  output logic [7:0]    out_coreid,
  output logic          overflow
);

  logic [FCSR_W-1:0]   shadow;
  logic [FCSR_W-1:0]   shadow_nxt;
  logic [FFLAGS_W-1:0] flags_nxt;
  logic [FRM_W-1:0]    frm_nxt;
  logic                push_req;
  logic                pop;
  logic                empty;
  logic                full;
  snap_t               push_snap;
  snap_t               head_snap;

  always_comb begin
    frm_nxt   = frm_wen ? frm_wdata : shadow[FRM_LSB +: FRM_W];
    flags_nxt = shadow[FFLAGS_W-1:0]
              | (fflags_valid ? fflags : '0);
    shadow_nxt = shadow;
    if (commit_valid) begin
      shadow_nxt = fcsr_wen ? fcsr_wdata : {frm_nxt, flags_nxt};
    end
  end

`ifdef DIFFTEST_FPCSR_CHANGE_ONLY_EN
  logic [FCSR_W-1:0] last_enq;

  assign push_req = commit_valid && (shadow_nxt != last_enq);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_enq <= '0;
    end else if (push_req) begin
      last_enq <= shadow_nxt;
    end
  end
`else
  assign push_req = commit_valid;
`endif

  assign pop = out_enable && out_ready;

  always_comb begin
    push_snap.fcsr   = fcsr_ext(shadow_nxt);
    push_snap.coreid = io_coreid;
  end

  difftest_snap_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(snap_t))
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_snap),
    .pop       (pop),
    .head      (head_snap),
    .empty     (empty),
    .full      (full)
  );

  // Stale storage is masked so an empty queue always reads zero.
  assign out_enable = !empty;
  assign out_fcsr   = empty ? '0 : head_snap.fcsr;
  assign out_coreid = empty ? '0 : head_snap.coreid;

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow   <= '0;
      overflow <= 1'b0;
    end else begin
      shadow <= shadow_nxt;
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_difftest_fpcsr_collector.sv
// Directed and randomized checks of the fpcsr collector against
// a queue-based reference model.
module tb_difftest_fpcsr_collector;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  io_coreid;
  logic        commit_valid;
  logic        fflags_valid;
  logic [4:0]  fflags;
  logic        frm_wen;
  logic [2:0]  frm_wdata;
  logic        fcsr_wen;
  logic [7:0]  fcsr_wdata;
  logic        out_ready;
  logic        out_enable;
  logic [63:0] out_fcsr;
  logic [7:0]  out_coreid;
  logic        overflow;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [7:0]  m_shadow;
  logic [7:0]  m_last;
  logic        m_ovf;
  logic [15:0] m_q[$];

  always #5 clock = ~clock;

  difftest_fpcsr_collector #(.FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_coreid    (io_coreid),
    .commit_valid (commit_valid),
    .fflags_valid (fflags_valid),
    .fflags       (fflags),
    .frm_wen      (frm_wen),
    .frm_wdata    (frm_wdata),
    .fcsr_wen     (fcsr_wen),
    .fcsr_wdata   (fcsr_wdata),
    .out_ready    (out_ready),
    .out_enable   (out_enable),
    .out_fcsr     (out_fcsr),
    .out_coreid   (out_coreid),
    .overflow     (overflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 0; commit_valid = 0; fflags_valid = 0; fflags = 0;
    frm_wen = 0; frm_wdata = 0; fcsr_wen = 0; fcsr_wdata = 0;
  endtask

  // Architectural rules applied to the inputs present at the edge.
  task automatic model_edge();
    bit do_pop;
    bit want;
    logic [7:0] nv;
    if (reset) begin
      m_shadow = 0; m_last = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    do_pop = (m_q.size() != 0) && out_ready;
    if (do_pop) void'(m_q.pop_front());
    if (!commit_valid) return;
    if (fcsr_wen) nv = fcsr_wdata;
    else begin
      nv[7:5] = frm_wen ? frm_wdata : m_shadow[7:5];
      nv[4:0] = m_shadow[4:0] | (fflags_valid ? fflags : 5'd0);
    end
    m_shadow = nv;
`ifdef DIFFTEST_FPCSR_CHANGE_ONLY_EN
    want = (nv != m_last);
    if (want) m_last = nv;
`else
    want = 1;
`endif
    if (want) begin
      if (m_q.size() < DEPTH || do_pop) m_q.push_back({io_coreid, nv});
      else m_ovf = 1;
    end
  endtask

  task automatic step();
    logic [15:0] h;
    @(posedge clock);
    model_edge();
    #1;
    h = (m_q.size() != 0) ? m_q[0] : 16'h0;
    chk("m_enable", 64'(out_enable), 64'(m_q.size() != 0));
    chk("m_fcsr", out_fcsr, {56'h0, h[7:0]});
    chk("m_coreid", 64'(out_coreid), 64'(h[15:8]));
    chk("m_overflow", 64'(overflow), 64'(m_ovf));
  endtask

  initial begin
    int n;
    int exp_n;
    m_shadow = 0; m_last = 0; m_ovf = 0;
    idle();
    io_coreid = 8'h3C;
    out_ready = 1;
    reset = 1;
    step();
    step();
    chk("rst_enable", 64'(out_enable), 64'h0);
    chk("rst_fcsr", out_fcsr, 64'h0);
    chk("rst_coreid", 64'(out_coreid), 64'h0);
    chk("rst_overflow", 64'(overflow), 64'h0);

    idle();
    commit_valid = 1; fflags_valid = 1; fflags = 5'h01;
    step();
    chk("flag_en", 64'(out_enable), 64'h1);
    chk("flag_fcsr", out_fcsr, 64'h01);
    chk("flag_coreid", 64'(out_coreid), 64'h3C);

    idle();
    commit_valid = 1; frm_wen = 1; frm_wdata = 3'b010;
    fflags_valid = 1; fflags = 5'h04;
    step();
    chk("frm_fcsr", out_fcsr, 64'h45);

    idle();
    commit_valid = 1; fcsr_wen = 1; fcsr_wdata = 8'hE0;
    fflags_valid = 1; fflags = 5'h1F;
    frm_wen = 1; frm_wdata = 3'b111;
    step();
    chk("fcsr_prio", out_fcsr, 64'hE0);

    idle();
    fflags_valid = 1; fflags = 5'h1F; fcsr_wen = 1;
    step();
    chk("nocommit_empty", 64'(out_enable), 64'h0);

    // Fill past depth with the sink stalled
    out_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      idle();
      commit_valid = 1; fcsr_wen = 1;
      fcsr_wdata = 8'(i * 8'h11);
      step();
    end
    idle();
    chk("full_ovf", 64'(overflow), 64'h1);
    chk("full_head", out_fcsr, 64'h11);
    out_ready = 1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("drain_order", out_fcsr, 64'(i * 8'h11));
    end
    step();
    chk("drain_empty", 64'(out_enable), 64'h0);
    chk("ovf_sticky", 64'(overflow), 64'h1);

    reset = 1;
    step();
    chk("ovf_clear", 64'(overflow), 64'h0);

    // Repeated identical value
    idle();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      commit_valid = 1; fcsr_wen = 1; fcsr_wdata = 8'h20;
      step();
    end
    idle();
    out_ready = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_enable) n++;
      step();
    end
`ifdef DIFFTEST_FPCSR_CHANGE_ONLY_EN
    exp_n = 1;
`else
    exp_n = 3;
`endif
    chk("same_count", 64'(n), 64'(exp_n));

    // Reset wins over queued entries and a commit
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      commit_valid = 1; fflags_valid = 1; fflags = 5'(1 << i);
      step();
    end
    idle();
    reset = 1; commit_valid = 1; fflags_valid = 1; fflags = 5'h10;
    out_ready = 1;
    step();
    chk("rstq_enable", 64'(out_enable), 64'h0);
    idle();
    step();
    chk("rstq_empty", 64'(out_enable), 64'h0);
    commit_valid = 1; fflags_valid = 1; fflags = 5'h01;
    step();
    chk("rstq_shadow", out_fcsr, 64'h01);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 79) == 0);
      commit_valid = ($urandom_range(0, 9) < 6);
      fflags_valid = $urandom_range(0, 1);
      fflags       = 5'($urandom);
      frm_wen      = ($urandom_range(0, 3) == 0);
      frm_wdata    = 3'($urandom);
      fcsr_wen     = ($urandom_range(0, 5) == 0);
      fcsr_wdata   = ($urandom_range(0, 1) != 0) ? 8'h20 : 8'($urandom);
      out_ready    = ($urandom_range(0, 9) < 6);
      io_coreid    = 8'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/difftest_fpcsr_collector.md
DIFFTEST_FPCSR_COLLECTOR -- requirements
Module: difftest_fpcsr_collector

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, snapshot queue entries (power of two, >=2).
REQ-002 SHALL have port clock  input  1  sole clock, all state rising-edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port io_coreid  input  8  hart id, passed through to out_coreid.
REQ-005 SHALL have port commit_valid  input  1  an FP-affecting instruction commits this cycle.
REQ-006 SHALL have port fflags_valid  input  1  fflags carries accrued exception flags.
REQ-007 SHALL have port fflags  input  5  accrued flags, ORed into the shadow fflags.
REQ-008 SHALL have port frm_wen  input  1  rounding-mode write.
REQ-009 SHALL have port frm_wdata  input  3  new frm.
REQ-010 SHALL have port fcsr_wen  input  1  full fcsr write.
REQ-011 SHALL have port fcsr_wdata  input  8  new {frm, fflags}.
REQ-012 SHALL have port out_ready  input  1  difftest sink accepts; tied 1 when the sink has no back-pressure.
REQ-013 SHALL have port out_enable  output  1  snapshot valid, drives the sink enable.
REQ-014 SHALL have port out_fcsr  output  64  snapshot; [4:0] fflags, [7:5] frm, [63:8] zero.
REQ-015 SHALL have port out_coreid  output  8  io_coreid registered alongside the snapshot.
REQ-016 SHALL have port overflow  output  1  sticky: a snapshot was dropped.

Function
REQ-017 SHALL keep an 8-bit shadow fcsr; next = fcsr_wen ? fcsr_wdata : {frm_wen ? frm_wdata : frm, fflags_shadow | (fflags_valid ? fflags : 0)}.
REQ-018 SHALL give fcsr_wen priority: frm_wen and fflags_valid in the same cycle are discarded.
REQ-019 SHALL update the shadow only when commit_valid=1; the write strobes are ignored otherwise.
REQ-020 SHALL enqueue the post-update shadow, zero-extended to 64 bits, plus io_coreid, on each commit_valid cycle.
REQ-021 SHALL assert out_enable = FIFO non-empty, with out_fcsr/out_coreid from the FIFO head.
REQ-022 SHALL pop when out_enable && out_ready.
REQ-023 SHALL present a snapshot pushed into an empty FIFO at edge N on out_* in cycle N+1, a 1-cycle latency with no combinational path from inputs to outputs.
REQ-024 SHALL handle a push while full: accepted if a pop occurs in the same cycle; otherwise dropped, with overflow set and the shadow still updated.
REQ-025 SHALL, when push and pop coincide on a non-empty FIFO, leave occupancy unchanged and preserve order.
REQ-026 SHALL wrap the read and write pointers modulo FIFO_DEPTH, with a separate count for full/empty.

Reset
REQ-027 SHALL, on reset, clear the shadow to 0, empty the FIFO, and force out_enable=0, out_fcsr=0, out_coreid=0, overflow=0.
REQ-028 SHALL have reset override any simultaneous commit, pop or write; queued snapshots are discarded, not flushed.

Configuration
REQ-029 SHALL honour macro DIFFTEST_FPCSR_CHANGE_ONLY_EN: when defined, a commit enqueues only if the new shadow differs from the last enqueued value (register reset 0); when undefined, every commit enqueues.

Structure
REQ-030 SHALL place the FCSR field widths/offsets (FFLAGS_W=5, FRM_W=3, FRM_LSB=5) and the snapshot struct typedef (fcsr[63:0], coreid[7:0]) in package difftest_fpcsr_pkg.
REQ-031 SHALL implement the queue as sub-module difftest_snap_fifo (synchronous, count-based, parameterised depth/width).

Verification
REQ-032 SHALL cover: reset, then commit with fflags_valid, fflags=5'h01 -> next cycle out_enable=1, out_fcsr=64'h01.
REQ-033 SHALL cover: commit with frm_wen=1, frm_wdata=3'b010, fflags_valid, fflags=5'h04, from shadow 0x01 -> out_fcsr=64'h45.
REQ-034 SHALL cover: same-cycle fcsr_wen=1, fcsr_wdata=8'hE0, fflags_valid, fflags=5'h1F -> out_fcsr=64'hE0.
REQ-035 SHALL cover: out_ready=0 and 5 commits with FIFO_DEPTH=4 -> 4 snapshots held, overflow=1, in-order drain of 4 once ready=1.
REQ-036 SHALL cover: with DIFFTEST_FPCSR_CHANGE_ONLY_EN, 3 commits with an unchanged value 0x20 -> exactly one snapshot; without the macro -> three.
REQ-037 SHALL cover: reset asserted with 2 queued entries and a commit in the same cycle -> next cycle out_enable=0, FIFO empty, shadow=0.
